// File: rtl/fifo_peripheral_pkg.sv
// Shared register map and status-bit layout for the memory-mapped FIFO peripheral.
package fifo_peripheral_pkg;

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_COUNT  = 8'h02;
    localparam logic [7:0] ADDR_THRESH = 8'h03;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_UDF   = 2;
    localparam int unsigned ST_OVF   = 3;

    // Assemble the STATUS register image from its individual flags.
    function automatic logic [7:0] build_status(input logic ovf, input logic udf,
                                                input logic full, input logic empty);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_OVF]   = ovf;
        s[ST_UDF]   = udf;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/fifo_peripheral_sync_fifo.sv
// Byte-wide synchronous FIFO; refuses push when full / pop when empty and
// reports each refused attempt as a one-cycle ovf/udf pulse.
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 wdata,
    output logic [7:0]                 rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // Qualify strobes against occupancy and flag refused attempts.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        ovf       = 1'b0;
        udf       = 1'b0;
        if (push) begin
            do_push_s = !full;
            ovf       = full;
        end else begin
            do_push_s = 1'b0;
        end
        if (pop) begin
            do_pop_s = !empty;
            udf      = empty;
        end else begin
            do_pop_s = 1'b0;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fifo_peripheral.sv
// Bus-facing FIFO peripheral: address decode, sticky error flags, threshold
// register, one-cycle registered response and level interrupt.
module fifo_peripheral
    import fifo_peripheral_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int THRESH_RST = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       trans,
    input  logic       write,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    output logic       readyout,
    output logic [7:0] rdata,
    output logic       irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             push_s;
    logic             pop_s;
    logic             status_clr_s;
    logic             thresh_wr_s;
    logic [7:0]       fifo_rdata_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_ovf_s;
    logic             fifo_udf_s;
    logic [7:0]       count8_s;
    logic [7:0]       read_mux_s;
    logic             ovf_r;
    logic             udf_r;
    logic [7:0]       thresh_r;
    logic             readyout_r;
    logic [7:0]       rdata_r;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .ovf   (fifo_ovf_s),
        .udf   (fifo_udf_s)
    );

    assign count8_s = 8'(fifo_count_s);

    // Decode the current transfer into FIFO strobes and register writes.
    always_comb begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        status_clr_s = 1'b0;
        thresh_wr_s  = 1'b0;
        if (trans) begin
            push_s       = write  && (waddr == ADDR_DATA);
            pop_s        = !write && (waddr == ADDR_DATA);
            status_clr_s = write  && (waddr == ADDR_STATUS);
            thresh_wr_s  = write  && (waddr == ADDR_THRESH);
        end else begin
            push_s = 1'b0;
        end
    end

    // Read data mux; an empty pop yields zero rather than stale storage.
    always_comb begin
        read_mux_s = 8'h00;
        case (waddr)
            ADDR_DATA:   read_mux_s = fifo_empty_s ? 8'h00 : fifo_rdata_s;
            ADDR_STATUS: read_mux_s = build_status(ovf_r, udf_r, fifo_full_s, fifo_empty_s);
            ADDR_COUNT:  read_mux_s = count8_s;
            ADDR_THRESH: read_mux_s = thresh_r;
            default:     read_mux_s = 8'h00;
        endcase
    end

    // Sticky error flags; set and write-1-to-clear never coincide.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (fifo_ovf_s) begin
                ovf_r <= 1'b1;
            end else if (status_clr_s && wdata[ST_OVF]) begin
                ovf_r <= 1'b0;
            end
            if (fifo_udf_s) begin
                udf_r <= 1'b1;
            end else if (status_clr_s && wdata[ST_UDF]) begin
                udf_r <= 1'b0;
            end
        end
    end

    // Interrupt threshold register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            thresh_r <= 8'(THRESH_RST);
        end else if (thresh_wr_s) begin
            thresh_r <= wdata;
        end
    end

    // Response registers: writes echo wdata, reads capture the pre-edge value.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            readyout_r <= 1'b0;
            rdata_r    <= 8'h00;
        end else begin
            readyout_r <= trans;
            if (trans) begin
                rdata_r <= write ? wdata : read_mux_s;
            end
        end
    end

    assign readyout = readyout_r;
    assign rdata    = rdata_r;
    assign irq      = (thresh_r != 8'h00) && (count8_s >= thresh_r);

endmodule

// File: tb/tb_fifo_peripheral.sv
// Directed plus randomized bench for fifo_peripheral against a queue-based model.
module tb_fifo_peripheral;

    localparam int DEPTH      = 8;
    localparam int THRESH_RST = 1;

    logic       clock;
    logic       rst;
    logic       trans;
    logic       write;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       readyout;
    logic [7:0] rdata;
    logic       irq;

    int vectors;
    int miscompares;

    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_udf;
    logic [7:0] m_thresh;
    logic [7:0] m_rdata;
    logic [7:0] got;

    fifo_peripheral #(.DEPTH(DEPTH), .THRESH_RST(THRESH_RST)) dut (
        .clock    (clock),
        .rst      (rst),
        .trans    (trans),
        .write    (write),
        .waddr    (waddr),
        .wdata    (wdata),
        .readyout (readyout),
        .rdata    (rdata),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_irq();
        return (m_thresh != 8'h00) && (q.size() >= int'(m_thresh));
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_thresh = 8'(THRESH_RST);
        m_rdata  = 8'h00;
    endtask

    // Apply the transfer's effect to the model, returning the expected response data.
    task automatic model_xfer(input bit w, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = 8'h00;
        if (w) begin
            r = d;
            if (a == 8'h00) begin
                if (q.size() == DEPTH) m_ovf = 1'b1;
                else q.push_back(d);
            end else if (a == 8'h01) begin
                if (d[2]) m_udf = 1'b0;
                if (d[3]) m_ovf = 1'b0;
            end else if (a == 8'h03) begin
                m_thresh = d;
            end
        end else begin
            case (a)
                8'h00: begin
                    if (q.size() == 0) begin
                        m_udf = 1'b1;
                        r = 8'h00;
                    end else begin
                        r = q.pop_front();
                    end
                end
                8'h01: r = {4'b0000, m_ovf, m_udf, q.size() == DEPTH, q.size() == 0};
                8'h02: r = 8'(q.size());
                8'h03: r = m_thresh;
                default: r = 8'h00;
            endcase
        end
        m_rdata = r;
    endtask

    task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] obs);
        @(negedge clock);
        trans = 1'b1;
        write = w;
        waddr = a;
        wdata = d;
        model_xfer(w, a, d);
        @(posedge clock);
        #1;
        chk("readyout", {7'd0, readyout}, 8'h01);
        chk("rdata", rdata, m_rdata);
        chk("irq", {7'd0, irq}, {7'd0, model_irq()});
        obs = rdata;
    endtask

    task automatic idle();
        @(negedge clock);
        trans = 1'b0;
        write = 1'b0;
        waddr = 8'($urandom);
        wdata = 8'($urandom);
        @(posedge clock);
        #1;
        chk("idle_readyout", {7'd0, readyout}, 8'h00);
        chk("idle_rdata", rdata, m_rdata);
        chk("idle_irq", {7'd0, irq}, {7'd0, model_irq()});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        trans = 1'b0;
        write = 1'b0;
        waddr = 8'h00;
        wdata = 8'h00;
        model_reset();
        #12;
        chk("reset_readyout", {7'd0, readyout}, 8'h00);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_irq", {7'd0, irq}, 8'h00);
        @(negedge clock);
        rst = 1'b0;

        // Reset register values.
        xfer(1'b0, 8'h01, 8'h00, got); chk("rst_status", got, 8'h01);
        xfer(1'b0, 8'h02, 8'h00, got); chk("rst_count", got, 8'h00);
        xfer(1'b0, 8'h03, 8'h00, got); chk("rst_thresh", got, 8'h01);
        idle();

        // Back-to-back push/pop.
        xfer(1'b1, 8'h00, 8'hA5, got);
        xfer(1'b1, 8'h00, 8'h3C, got);
        xfer(1'b0, 8'h00, 8'h00, got); chk("pop1", got, 8'hA5);
        xfer(1'b0, 8'h00, 8'h00, got); chk("pop2", got, 8'h3C);
        idle();

        // Overflow: nine pushes into eight entries.
        for (int i = 0; i < 9; i++) xfer(1'b1, 8'h00, 8'(8'h10 + i), got);
        xfer(1'b0, 8'h01, 8'h00, got); chk("full_status", got, 8'h0A);
        xfer(1'b0, 8'h02, 8'h00, got); chk("full_count", got, 8'h08);
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 8'h00, 8'h00, got);
            chk("drain_order", got, 8'(8'h10 + i));
        end

        // Underflow and write-1-to-clear.
        xfer(1'b0, 8'h00, 8'h00, got); chk("empty_pop", got, 8'h00);
        xfer(1'b0, 8'h01, 8'h00, got); chk("udf_status", got, 8'h0D);
        xfer(1'b1, 8'h01, 8'h08, got);
        xfer(1'b1, 8'h01, 8'h04, got);
        xfer(1'b0, 8'h01, 8'h00, got); chk("cleared_status", got, 8'h01);
        xfer(1'b0, 8'h07, 8'h00, got); chk("unmapped_read", got, 8'h00);

        // Threshold interrupt.
        xfer(1'b1, 8'h03, 8'h03, got);
        xfer(1'b1, 8'h00, 8'h01, got); chk("irq_below1", {7'd0, irq}, 8'h00);
        xfer(1'b1, 8'h00, 8'h02, got); chk("irq_below2", {7'd0, irq}, 8'h00);
        xfer(1'b1, 8'h00, 8'h03, got); chk("irq_at_thresh", {7'd0, irq}, 8'h01);
        xfer(1'b1, 8'h03, 8'h00, got); chk("irq_disabled", {7'd0, irq}, 8'h00);
        xfer(1'b1, 8'h03, 8'h09, got); chk("irq_above_depth", {7'd0, irq}, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int sel;
            bit w;
            logic [7:0] a;
            logic [7:0] d;
            sel = int'($urandom_range(0, 9));
            w   = 1'($urandom);
            d   = 8'($urandom);
            case (sel)
                0, 1, 2, 3: a = 8'h00;
                4:          a = 8'h01;
                5:          a = 8'h02;
                6:          begin a = 8'h03; d = 8'($urandom_range(0, 10)); end
                7:          a = 8'($urandom_range(4, 255));
                default:    a = 8'h00;
            endcase
            if (sel == 9) idle();
            else xfer(w, a, d, got);
        end

        // Reset in the middle of a burst with four entries queued.
        xfer(1'b1, 8'h03, 8'h01, got);
        while (q.size() > 0) xfer(1'b0, 8'h00, 8'h00, got);
        for (int i = 0; i < 4; i++) xfer(1'b1, 8'h00, 8'(8'hC0 + i), got);
        chk("pre_reset_irq", {7'd0, irq}, 8'h01);
        @(negedge clock);
        trans = 1'b1;
        write = 1'b0;
        waddr = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_readyout", {7'd0, readyout}, 8'h00);
        chk("midrst_rdata", rdata, 8'h00);
        chk("midrst_irq", {7'd0, irq}, 8'h00);
        model_reset();
        @(negedge clock);
        rst   = 1'b0;
        trans = 1'b0;
        xfer(1'b0, 8'h02, 8'h00, got); chk("post_rst_count", got, 8'h00);
        xfer(1'b0, 8'h03, 8'h00, got); chk("post_rst_thresh", got, 8'h01);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
